// File: rtl/div_iter_uns_sgn.sv
// Iterative restoring divider (unsigned or per-op signed), rowsPerCycle quotient bits per clock.
// Latency: OutValid widthX/rowsPerCycle+1 cycles after accept; 1 cycle when Y==0.
// Backpressure: result held in DONE until OutReady; a new accept is allowed on the release cycle.
module div_iter_uns_sgn #(
  parameter int widthX       = 16,
  parameter int widthY       = 8,
  parameter int rowsPerCycle = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              InValid,
  output logic              InReady,
  input  logic [widthX-1:0] X,
  input  logic [widthY-1:0] Y,
  input  logic              Signed,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [widthX-1:0] Q,
  output logic [widthY-1:0] R,
  output logic              DivZero
);

  localparam int C  = widthX / rowsPerCycle;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (rowsPerCycle < 1 || (widthX % rowsPerCycle) != 0) begin : g_bad_rows
    $error("div_iter_uns_sgn: rowsPerCycle must be >= 1 and divide widthX");
  end
  if (widthY > widthX || widthY < 1) begin : g_bad_width
    $error("div_iter_uns_sgn: widthY must be in 1..widthX");
  end

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Dividend magnitude shifts out at the MSB while quotient bits shift in at the LSB.
  logic [widthX-1:0] dvd_q, dvd_d;
  logic [widthY-1:0] rem_q, rem_d;
  logic [widthY-1:0] ymag_q, ymag_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [widthX-1:0] q_q, q_d;
  logic [widthY-1:0] r_q, r_d;
  logic              dz_q, dz_d;

  logic              accept;
  logic [widthX-1:0] x_mag;
  logic [widthY-1:0] y_mag;
  logic [widthY:0]   rem_v;
  logic [widthX-1:0] dvd_v;
  logic [widthY+1:0] sub_v;

  assign InReady  = !RST && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && OutReady));
  assign accept   = InValid && InReady;
  assign OutValid = (state_q == ST_DONE);
  assign Q        = q_q;
  assign R        = r_q;
  assign DivZero  = dz_q;

  assign x_mag = (Signed && X[widthX-1]) ? -X : X;
  assign y_mag = (Signed && Y[widthY-1]) ? -Y : Y;

  // Restoring rows: the borrow of (partial remainder - divisor) decides the quotient bit.
  always_comb begin
    rem_v = {1'b0, rem_q};
    dvd_v = dvd_q;
    sub_v = '0;
    for (int i = 0; i < rowsPerCycle; i++) begin
      rem_v = {rem_v[widthY-1:0], dvd_v[widthX-1]};
      dvd_v = {dvd_v[widthX-2:0], 1'b0};
      sub_v = {1'b0, rem_v} - {2'b00, ymag_q};
      if (!sub_v[widthY+1]) begin
        rem_v    = sub_v[widthY:0];
        dvd_v[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    ymag_d  = ymag_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      ST_BUSY: begin
        dvd_d = dvd_v;
        rem_d = rem_v[widthY-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(C - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          q_d     = q_neg_q ? -dvd_v : dvd_v;
          r_d     = r_neg_q ? -rem_v[widthY-1:0] : rem_v[widthY-1:0];
          dz_d    = 1'b0;
        end
      end
      ST_DONE: begin
        if (OutReady) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Accept only happens in IDLE or DONE, so it overrides the DONE release above.
    if (accept) begin
      if (Y == '0) begin
        state_d = ST_DONE;
        q_d     = '1;
        r_d     = X[widthY-1:0];
        dz_d    = 1'b1;
      end else begin
        state_d = ST_BUSY;
        cnt_d   = '0;
        dvd_d   = x_mag;
        rem_d   = '0;
        ymag_d  = y_mag;
        q_neg_d = Signed && (X[widthX-1] ^ Y[widthY-1]);
        r_neg_d = Signed && X[widthX-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      ymag_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      ymag_q  <= ymag_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

endmodule
